// File: rtl/lc3_mem_pkg.sv
// Shared definitions for the LC-3 memory arbiter: FSM states, port ids and
// the default read-access wait length.
package lc3_mem_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        WAIT,
        DATA,
        WRITE,
        DONE
    } mem_state_e;

    localparam logic PORT_CPU  = 1'b0;
    localparam logic PORT_VIEW = 1'b1;

    localparam int unsigned WAIT_CYCLES_DEFAULT = 1;

endpackage

// File: rtl/mem_rr_arbiter.sv
// Two-input round-robin arbiter: a lone request wins, a tie goes to the
// port that was not granted last.
module mem_rr_arbiter
    import lc3_mem_pkg::*;
(
    input  logic i_req_cpu,
    input  logic i_req_view,
    input  logic i_last_grant,
    output logic o_valid,
    output logic o_winner
);

    always_comb begin
        o_valid  = i_req_cpu | i_req_view;
        o_winner = PORT_CPU;
        if (i_req_cpu && i_req_view) begin
            o_winner = (i_last_grant == PORT_CPU) ? PORT_VIEW : PORT_CPU;
        end else if (i_req_view) begin
            o_winner = PORT_VIEW;
        end
    end

endmodule

// File: rtl/memory_arbiter.sv
// Shares one LC-3 style memory (MAR/MDR/WE strobes) between a CPU port and a
// debug/loader port; one access at a time, non-preemptible, round-robin on ties.
module memory_arbiter
    import lc3_mem_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = WAIT_CYCLES_DEFAULT
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Cpu_Req,
    input  logic        Cpu_WE,
    input  logic [15:0] Cpu_Addr,
    input  logic [15:0] Cpu_Data,
    output logic        Cpu_Ready,
    output logic [15:0] Cpu_Rdata,
    input  logic        View_Req,
    input  logic        View_WE,
    input  logic [15:0] View_Addr,
    input  logic [15:0] View_Data,
    output logic        View_Ready,
    output logic [15:0] View_Rdata,
    output logic [15:0] Bus_Out,
    output logic        Load_MAR,
    output logic        Load_MDR,
    output logic        Memory_WE,
    input  logic [15:0] Memory_Out,
    output logic        Busy,
    output logic        Grant
);

    mem_state_e  r_state;
    logic [2:0]  r_wait_cnt;
    logic        r_we;
    logic [15:0] r_addr;
    logic [15:0] r_data;
    logic        r_grant;
    logic        r_rr_ptr;
    logic        r_busy;
    logic [15:0] r_bus_out;
    logic        r_load_mar;
    logic        r_load_mdr;
    logic        r_mem_we;
    logic        r_cpu_ready;
    logic        r_view_ready;
    logic [15:0] r_cpu_rdata;
    logic [15:0] r_view_rdata;

    logic        w_valid;
    logic        w_winner;

    mem_rr_arbiter u_rr_arbiter (
        .i_req_cpu   (Cpu_Req),
        .i_req_view  (View_Req),
        .i_last_grant(r_rr_ptr),
        .o_valid     (w_valid),
        .o_winner    (w_winner)
    );

    // Outputs are registered: each transition loads the strobes of the state it enters.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state      <= IDLE;
            r_wait_cnt   <= 3'd0;
            r_we         <= 1'b0;
            r_addr       <= 16'h0000;
            r_data       <= 16'h0000;
            r_grant      <= PORT_CPU;
            r_rr_ptr     <= PORT_VIEW;
            r_busy       <= 1'b0;
            r_bus_out    <= 16'h0000;
            r_load_mar   <= 1'b0;
            r_load_mdr   <= 1'b0;
            r_mem_we     <= 1'b0;
            r_cpu_ready  <= 1'b0;
            r_view_ready <= 1'b0;
            r_cpu_rdata  <= 16'h0000;
            r_view_rdata <= 16'h0000;
        end else begin
            r_bus_out    <= 16'h0000;
            r_load_mar   <= 1'b0;
            r_load_mdr   <= 1'b0;
            r_mem_we     <= 1'b0;
            r_cpu_ready  <= 1'b0;
            r_view_ready <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (w_valid) begin
                        r_grant    <= w_winner;
                        r_rr_ptr   <= w_winner;
                        r_we       <= (w_winner == PORT_VIEW) ? View_WE   : Cpu_WE;
                        r_addr     <= (w_winner == PORT_VIEW) ? View_Addr : Cpu_Addr;
                        r_data     <= (w_winner == PORT_VIEW) ? View_Data : Cpu_Data;
                        r_bus_out  <= (w_winner == PORT_VIEW) ? View_Addr : Cpu_Addr;
                        r_load_mar <= 1'b1;
                        r_busy     <= 1'b1;
                        r_state    <= ADDR;
                    end
                end
                ADDR: begin
                    if (r_we) begin
                        r_bus_out  <= r_data;
                        r_load_mdr <= 1'b1;
                        r_state    <= DATA;
                    end else begin
                        r_wait_cnt <= 3'(WAIT_CYCLES - 1);
                        r_state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (r_wait_cnt == 3'd0) begin
                        if (r_grant == PORT_VIEW) begin
                            r_view_rdata <= Memory_Out;
                            r_view_ready <= 1'b1;
                        end else begin
                            r_cpu_rdata <= Memory_Out;
                            r_cpu_ready <= 1'b1;
                        end
                        r_state <= DONE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt - 3'd1;
                    end
                end
                DATA: begin
                    r_bus_out <= r_data;
                    r_mem_we  <= 1'b1;
                    r_state   <= WRITE;
                end
                WRITE: begin
                    r_cpu_ready  <= (r_grant == PORT_CPU);
                    r_view_ready <= (r_grant == PORT_VIEW);
                    r_state      <= DONE;
                end
                DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign Cpu_Ready  = r_cpu_ready;
    assign Cpu_Rdata  = r_cpu_rdata;
    assign View_Ready = r_view_ready;
    assign View_Rdata = r_view_rdata;
    assign Bus_Out    = r_bus_out;
    assign Load_MAR   = r_load_mar;
    assign Load_MDR   = r_load_mdr;
    assign Memory_WE  = r_mem_we;
    assign Busy       = r_busy;
    assign Grant      = r_grant;

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter: a WAIT_CYCLES=1 instance for most checks and
// a WAIT_CYCLES=3 instance for the longer read, each with its own MAR/MDR memory.
module tb_memory_arbiter;

    localparam int unsigned W1 = 1;

    logic        Clk;
    logic        Reset;
    logic        Cpu_Req, Cpu_WE, View_Req, View_WE;
    logic [15:0] Cpu_Addr, Cpu_Data, View_Addr, View_Data;

    logic        Cpu_Ready1, View_Ready1, Load_MAR1, Load_MDR1, Memory_WE1, Busy1, Grant1;
    logic [15:0] Cpu_Rdata1, View_Rdata1, Bus_Out1, Memory_Out1;
    logic        Cpu_Ready3, View_Ready3, Load_MAR3, Load_MDR3, Memory_WE3, Busy3, Grant3;
    logic [15:0] Cpu_Rdata3, View_Rdata3, Bus_Out3, Memory_Out3;

    logic [15:0] mem1 [0:65535];
    logic [15:0] mem3 [0:65535];
    logic [15:0] mar1, mdr1, mar3, mdr3;

    int n_total = 0;
    int n_bad   = 0;
    logic [15:0] exp_cpu_rd, exp_view_rd;

    memory_arbiter #(.WAIT_CYCLES(W1)) dut1 (
        .Clk(Clk), .Reset(Reset),
        .Cpu_Req(Cpu_Req), .Cpu_WE(Cpu_WE), .Cpu_Addr(Cpu_Addr), .Cpu_Data(Cpu_Data),
        .Cpu_Ready(Cpu_Ready1), .Cpu_Rdata(Cpu_Rdata1),
        .View_Req(View_Req), .View_WE(View_WE), .View_Addr(View_Addr), .View_Data(View_Data),
        .View_Ready(View_Ready1), .View_Rdata(View_Rdata1),
        .Bus_Out(Bus_Out1), .Load_MAR(Load_MAR1), .Load_MDR(Load_MDR1),
        .Memory_WE(Memory_WE1), .Memory_Out(Memory_Out1), .Busy(Busy1), .Grant(Grant1)
    );

    memory_arbiter #(.WAIT_CYCLES(3)) dut3 (
        .Clk(Clk), .Reset(Reset),
        .Cpu_Req(Cpu_Req), .Cpu_WE(Cpu_WE), .Cpu_Addr(Cpu_Addr), .Cpu_Data(Cpu_Data),
        .Cpu_Ready(Cpu_Ready3), .Cpu_Rdata(Cpu_Rdata3),
        .View_Req(View_Req), .View_WE(View_WE), .View_Addr(View_Addr), .View_Data(View_Data),
        .View_Ready(View_Ready3), .View_Rdata(View_Rdata3),
        .Bus_Out(Bus_Out3), .Load_MAR(Load_MAR3), .Load_MDR(Load_MDR3),
        .Memory_WE(Memory_WE3), .Memory_Out(Memory_Out3), .Busy(Busy3), .Grant(Grant3)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    assign Memory_Out1 = mem1[mar1];
    assign Memory_Out3 = mem3[mar3];

    // LC-3 memory: MAR/MDR load on the edge, write commits MDR at MAR on the edge.
    initial begin
        mar1 = 16'h0000; mdr1 = 16'h0000; mar3 = 16'h0000; mdr3 = 16'h0000;
        mem1[16'h3000] = 16'h1234; mem1[16'h0400] = 16'h1111;
        mem3[16'h3000] = 16'h1234; mem3[16'h0050] = 16'hCAFE;
        forever begin
            @(posedge Clk);
            if (Load_MAR1)  mar1 <= Bus_Out1;
            if (Load_MDR1)  mdr1 <= Bus_Out1;
            if (Memory_WE1) mem1[mar1] <= mdr1;
            if (Load_MAR3)  mar3 <= Bus_Out3;
            if (Load_MDR3)  mdr3 <= Bus_Out3;
            if (Memory_WE3) mem3[mar3] <= mdr3;
        end
    end

    typedef struct {
        logic        port;
        logic        we;
        logic [15:0] addr;
        logic [15:0] data;
        logic [15:0] exp_rdata;
    } vec_t;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // One access on dut1 with the cycle-by-cycle strobe pattern checked.
    task automatic do_access(input int idx, input vec_t v);
        if (v.port) begin
            View_Req = 1'b1; View_WE = v.we; View_Addr = v.addr; View_Data = v.data;
        end else begin
            Cpu_Req = 1'b1; Cpu_WE = v.we; Cpu_Addr = v.addr; Cpu_Data = v.data;
        end
        step();
        Cpu_Req = 1'b0; View_Req = 1'b0;
        chk($sformatf("v%0d_load_mar", idx), Load_MAR1, 1'b1);
        chk($sformatf("v%0d_bus_addr", idx), Bus_Out1, v.addr);
        chk($sformatf("v%0d_grant", idx), Grant1, v.port);
        chk($sformatf("v%0d_busy", idx), Busy1, 1'b1);
        if (!v.we) begin
            for (int i = 0; i < int'(W1); i++) begin
                step();
                chk($sformatf("v%0d_wait_bus", idx), Bus_Out1, 16'h0000);
                chk($sformatf("v%0d_wait_strobes", idx),
                    {Load_MAR1, Load_MDR1, Memory_WE1, Cpu_Ready1, View_Ready1}, 5'b00000);
            end
        end else begin
            step();
            chk($sformatf("v%0d_load_mdr", idx), {Load_MAR1, Load_MDR1, Memory_WE1}, 3'b010);
            chk($sformatf("v%0d_bus_data", idx), Bus_Out1, v.data);
            step();
            chk($sformatf("v%0d_mem_we", idx), {Load_MAR1, Load_MDR1, Memory_WE1}, 3'b001);
            chk($sformatf("v%0d_bus_hold", idx), Bus_Out1, v.data);
        end
        step();
        chk($sformatf("v%0d_ready", idx), {Cpu_Ready1, View_Ready1}, v.port ? 2'b01 : 2'b10);
        chk($sformatf("v%0d_done_bus", idx), Bus_Out1, 16'h0000);
        if (!v.we) begin
            if (v.port) exp_view_rd = v.exp_rdata;
            else        exp_cpu_rd  = v.exp_rdata;
        end
        chk($sformatf("v%0d_cpu_rdata", idx), Cpu_Rdata1, exp_cpu_rd);
        chk($sformatf("v%0d_view_rdata", idx), View_Rdata1, exp_view_rd);
        step();
        chk($sformatf("v%0d_idle", idx), {Busy1, Cpu_Ready1, View_Ready1}, 3'b000);
    endtask

    initial begin
        vec_t vecs [6];
        logic exp_g [3];
        bit   found;
        int   cnt;

        vecs[0] = '{1'b0, 1'b0, 16'h3000, 16'h0000, 16'h1234};
        vecs[1] = '{1'b1, 1'b1, 16'h0200, 16'hBEEF, 16'h0000};
        vecs[2] = '{1'b1, 1'b0, 16'h0200, 16'h0000, 16'hBEEF};
        vecs[3] = '{1'b0, 1'b1, 16'h0300, 16'h5A5A, 16'h0000};
        vecs[4] = '{1'b0, 1'b0, 16'h0300, 16'h0000, 16'h5A5A};
        vecs[5] = '{1'b1, 1'b0, 16'h3000, 16'h0000, 16'h1234};
        exp_g[0] = 1'b0; exp_g[1] = 1'b1; exp_g[2] = 1'b0;

        Reset = 1'b0;
        Cpu_Req = 1'b0; Cpu_WE = 1'b0; Cpu_Addr = 16'h0; Cpu_Data = 16'h0;
        View_Req = 1'b0; View_WE = 1'b0; View_Addr = 16'h0; View_Data = 16'h0;
        exp_cpu_rd = 16'h0000; exp_view_rd = 16'h0000;
        #2;
        chk("rst_busy", Busy1, 1'b0);
        chk("rst_bus", Bus_Out1, 16'h0000);
        chk("rst_strobes", {Load_MAR1, Load_MDR1, Memory_WE1, Cpu_Ready1, View_Ready1}, 5'b0);
        chk("rst_cpu_rdata", Cpu_Rdata1, 16'h0000);
        chk("rst_view_rdata", View_Rdata1, 16'h0000);
        chk("rst_grant", Grant1, 1'b0);
        step();
        Reset = 1'b1;

        for (int i = 0; i < 6; i++) do_access(i, vecs[i]);

        // Simultaneous held requests: CPU, View, CPU.
        Reset = 1'b0;
        #1;
        Reset = 1'b1;
        chk("rr_rst_rdata", {Cpu_Rdata1, View_Rdata1}, 32'h0);
        Cpu_Req = 1'b1; Cpu_WE = 1'b0; Cpu_Addr = 16'h3000;
        View_Req = 1'b1; View_WE = 1'b0; View_Addr = 16'h0200;
        for (int a = 0; a < 3; a++) begin
            found = 1'b0;
            cnt = 0;
            while (!found && cnt < 20) begin
                step();
                cnt++;
                if (Load_MAR1) found = 1'b1;
            end
            chk($sformatf("rr%0d_grant_seen", a), found, 1'b1);
            chk($sformatf("rr%0d_grant", a), Grant1, exp_g[a]);
            if (a == 2) begin
                Cpu_Req = 1'b0; View_Req = 1'b0;
            end
            found = 1'b0;
            cnt = 0;
            while (!found && cnt < 20) begin
                step();
                cnt++;
                if (Cpu_Ready1 || View_Ready1) found = 1'b1;
            end
            chk($sformatf("rr%0d_ready_seen", a), found, 1'b1);
            chk($sformatf("rr%0d_ready_owner", a), {Cpu_Ready1, View_Ready1},
                exp_g[a] ? 2'b01 : 2'b10);
            if (exp_g[a]) chk($sformatf("rr%0d_rdata", a), View_Rdata1, 16'hBEEF);
            else          chk($sformatf("rr%0d_rdata", a), Cpu_Rdata1, 16'h1234);
        end
        step();
        step();

        // Reset during WRITE must kill Memory_WE without a clock edge.
        Cpu_Req = 1'b1; Cpu_WE = 1'b1; Cpu_Addr = 16'h0400; Cpu_Data = 16'h7777;
        step();
        Cpu_Req = 1'b0;
        step();
        step();
        chk("rw_mem_we_high", Memory_WE1, 1'b1);
        #3;
        Reset = 1'b0;
        #1;
        chk("rw_mem_we_async", Memory_WE1, 1'b0);
        chk("rw_busy_async", Busy1, 1'b0);
        chk("rw_bus_async", Bus_Out1, 16'h0000);
        step();
        Reset = 1'b1;
        step();
        step();
        chk("rw_busy_after", Busy1, 1'b0);
        chk("rw_mem_unchanged", mem1[16'h0400], 16'h1111);

        // WAIT_CYCLES=3 instance: View read first, then CPU read with Req dropped.
        View_Req = 1'b1; View_WE = 1'b0; View_Addr = 16'h0050;
        step();
        View_Req = 1'b0;
        found = 1'b0;
        cnt = 0;
        while (!found && cnt < 20) begin
            step();
            cnt++;
            if (View_Ready3) found = 1'b1;
        end
        chk("w3_view_ready_seen", found, 1'b1);
        chk("w3_view_rdata", View_Rdata3, 16'hCAFE);
        step();
        step();
        Cpu_Req = 1'b1; Cpu_WE = 1'b0; Cpu_Addr = 16'h3000;
        step();
        Cpu_Req = 1'b0;
        chk("w3_load_mar", {Load_MAR3, Bus_Out3}, {1'b1, 16'h3000});
        for (int c = 2; c <= 4; c++) begin
            step();
            chk($sformatf("w3_not_ready_k%0d", c), Cpu_Ready3, 1'b0);
        end
        step();
        chk("w3_cpu_ready_k5", Cpu_Ready3, 1'b1);
        chk("w3_cpu_rdata", Cpu_Rdata3, 16'h1234);
        chk("w3_view_rdata_hold", View_Rdata3, 16'hCAFE);
        step();
        chk("w3_idle", Busy3, 1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/memory_arbiter.md
MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 Parameter: WAIT_CYCLES, 1, read-access cycles between the MAR load and the data capture; legal range 1..7.
REQ-002 Clk  in  1  system clock; all state updates on the rising edge.
REQ-003 Reset  in  1  asynchronous, active-low reset.
REQ-004 Cpu_Req  in  1  CPU access request; level, held until Cpu_Ready.
REQ-005 Cpu_WE  in  1  CPU access type: 1 write, 0 read; sampled at grant.
REQ-006 Cpu_Addr  in  16  CPU address; sampled at grant.
REQ-007 Cpu_Data  in  16  CPU write data; sampled at grant.
REQ-008 Cpu_Ready  out  1  one-cycle completion pulse to the CPU.
REQ-009 Cpu_Rdata  out  16  last CPU read data; registered.
REQ-010 View_Req, View_WE, View_Addr, View_Data  in  1/1/16/16  debug/loader port; same meanings as the CPU inputs.
REQ-011 View_Ready, View_Rdata  out  1/16  debug/loader port; same meanings as the CPU outputs.
REQ-012 Bus_Out  out  16  value presented to the memory MAR/MDR inputs.
REQ-013 Load_MAR, Load_MDR, Memory_WE  out  1  memory strobes; each high for exactly one cycle per use.
REQ-014 Memory_Out  in  16  memory read data.
REQ-015 Busy  out  1  high in every state except IDLE.
REQ-016 Grant  out  1  owner of the current or last access: 0 CPU, 1 View.

Function
REQ-017 FSM states SHALL be IDLE, ADDR, WAIT, DATA, WRITE and DONE.
REQ-018 IDLE: with any request high at an edge, the FSM SHALL latch the winner's WE/Addr/Data and Grant, then enter ADDR.
REQ-019 Arbitration: a single request wins; on simultaneous requests the port not granted last wins (round-robin); the pointer updates at each grant.
REQ-020 ADDR: Bus_Out = latched Addr and Load_MAR = 1; next state is WAIT if a read, DATA if a write.
REQ-021 WAIT: lasts exactly WAIT_CYCLES cycles, counted by a 3-bit down-counter; on exit, Memory_Out SHALL be captured into the granted port's Rdata and the FSM enters DONE.
REQ-022 DATA: Bus_Out = latched Data and Load_MDR = 1; next state is WRITE.
REQ-023 WRITE: Memory_WE = 1 for one cycle; Bus_Out holds the data; next state is DONE.
REQ-024 DONE: the granted port's Ready = 1 for one cycle; next state is IDLE (no back-to-back grant from DONE).
REQ-025 Latency, with the request sampled at edge k: a read's Ready is high in cycle k+2+WAIT_CYCLES; a write's Ready is high in cycle k+4.
REQ-026 Bus_Out SHALL be 0 in IDLE, WAIT and DONE; strobes are 0 outside their named state.
REQ-027 Requests are not preemptible: a higher-priority request arriving mid-access waits for IDLE.
REQ-028 A requester dropping Req mid-access: the access completes and Ready still pulses.
REQ-029 Rdata of the non-granted port SHALL hold its value; a write SHALL NOT modify either Rdata.
REQ-030 A requester holding Req through Ready is a new request at the next IDLE.

Reset
REQ-031 Reset low SHALL immediately force IDLE, all strobes/Ready/Busy 0, Bus_Out 0, both Rdata 0, Grant 0, and the round-robin pointer so that the CPU wins the first tie.
REQ-032 Reset asserted during WRITE SHALL drop Memory_WE asynchronously; no partial access resumes after reset.

Structure
REQ-033 Shared package lc3_mem_pkg SHALL hold the state enumeration, the PORT_CPU/PORT_VIEW constants and the WAIT_CYCLES default.
REQ-034 A single sub-module, mem_rr_arbiter (2-input round-robin; inputs requests plus pointer, outputs winner), SHALL be instantiated; everything else is flat.

Verification
REQ-035 CPU read: Addr=0x3000, memory holds 0x1234 at 0x3000, WAIT_CYCLES=1 -> Load_MAR with Bus_Out=0x3000 in cycle k+1, Cpu_Ready and Cpu_Rdata=0x1234 in cycle k+3.
REQ-036 View write: Addr=0x0200, Data=0xBEEF -> Load_MAR (0x0200) at k+1, Load_MDR (0xBEEF) at k+2, Memory_WE at k+3, View_Ready at k+4; a follow-up read returns 0xBEEF.
REQ-037 Simultaneous requests out of reset, both held for two accesses -> grants in order CPU, View, CPU; each Ready goes only to its owner.
REQ-038 Reset pulled low during WRITE -> Memory_WE falls without a clock edge; after release, Busy=0 and the memory location is unchanged.
REQ-039 WAIT_CYCLES=3, CPU read with Cpu_Req dropped after grant -> Cpu_Ready at k+5 and View_Rdata unchanged.
